stat_rd_sched: RTL

STAT_RD_SCHED -- requirements
Module: stat_rd_sched

---
 rtl/stat_pkt_pkg.sv | 16 +
 rtl/stat_rd_sched_if.sv | 39 +++
 rtl/stat_sweep_timer.sv | 95 +++++++++
 rtl/stat_rd_sched.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/stat_pkt_pkg.sv
// Shared types for the stat_pkt read scheduler.
//   state_e  : read FSM state (IDLE, or WAIT with one read outstanding)
//   req_id_e : which requester owns or last owned the stat_pkt read port
package stat_pkt_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  typedef enum logic {
    REQ_HOST  = 1'b0,
    REQ_SWEEP = 1'b1
  } req_id_e;

endpackage

// File: rtl/stat_rd_sched_if.sv
// Signal bundle for stat_rd_sched: host read port, sweep result port and
// the read port towards stat_pkt.
//   slave  : the scheduler's view (drives host/sweep results, rd strobe)
//   master : the surrounding system's view (host, sweep enable, stat_pkt)
interface stat_rd_sched_if #(
  parameter int A_WIDTH = 3,
  parameter int D_WIDTH = 32
);
  logic               host_req_i;
  logic [A_WIDTH-1:0] host_flow_num_i;
  logic               host_ack_o;
  logic [D_WIDTH-1:0] host_data_o;
  logic               host_data_val_o;
  logic               sweep_en_i;
  logic [A_WIDTH-1:0] sweep_flow_num_o;
  logic [D_WIDTH-1:0] sweep_data_o;
  logic               sweep_data_val_o;
  logic               sweep_done_o;
  logic               sweep_overrun_o;
  logic               timeout_err_o;
  logic               rd_stb_o;
  logic [A_WIDTH-1:0] rd_flow_num_o;
  logic [D_WIDTH-1:0] rd_data_i;
  logic               rd_data_val_i;

  modport slave (
    input  host_req_i, host_flow_num_i, sweep_en_i, rd_data_i, rd_data_val_i,
    output host_ack_o, host_data_o, host_data_val_o,
           sweep_flow_num_o, sweep_data_o, sweep_data_val_o, sweep_done_o,
           sweep_overrun_o, timeout_err_o, rd_stb_o, rd_flow_num_o
  );

  modport master (
    output host_req_i, host_flow_num_i, sweep_en_i, rd_data_i, rd_data_val_i,
    input  host_ack_o, host_data_o, host_data_val_o,
           sweep_flow_num_o, sweep_data_o, sweep_data_val_o, sweep_done_o,
           sweep_overrun_o, timeout_err_o, rd_stb_o, rd_flow_num_o
  );
endinterface

// File: rtl/stat_sweep_timer.sv
// Periodic sweep timer. Counts 0..SWEEP_PERIOD-1 while sweep_en_i is high;
// at the terminal count it starts a sweep over all flows (or flags an
// overrun if the previous sweep is still active).
//   clk_i, rst_i  : clock, synchronous active-high reset
//   sweep_en_i    : enables the period counter (low clears it)
//   grant_i       : scheduler granted the pending sweep read this cycle
//   done_i        : last flow of the sweep was delivered this cycle
//   req_o         : a sweep read is pending
//   flow_o        : flow number of the pending sweep read
//   overrun_o     : one-cycle pulse, period elapsed during an active sweep
module stat_sweep_timer
  import stat_pkt_pkg::*;
#(
  parameter int A_WIDTH      = 3,
  parameter int SWEEP_PERIOD = 1024
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               sweep_en_i,
  input  logic               grant_i,
  input  logic               done_i,
  output logic               req_o,
  output logic [A_WIDTH-1:0] flow_o,
  output logic               overrun_o
);

  localparam int               CW        = (SWEEP_PERIOD > 1) ? $clog2(SWEEP_PERIOD) : 1;
  localparam logic [CW-1:0]      CNT_LAST  = CW'(SWEEP_PERIOD - 1);
  localparam logic [A_WIDTH-1:0] FLOW_LAST = '1;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic               active_q, active_d;
  logic               pend_q, pend_d;
  logic [A_WIDTH-1:0] idx_q, idx_d;
  logic               overrun_q, overrun_d;
  logic               terminal;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    cnt_d     = cnt_q;
    active_d  = active_q;
    pend_d    = pend_q;
    idx_d     = idx_q;
    overrun_d = 1'b0;
    terminal  = sweep_en_i && (cnt_q == CNT_LAST);

    if (!sweep_en_i || terminal) cnt_d = '0;
    else                         cnt_d = cnt_q + CW'(1);

    // The index wraps naturally; issuing the last flow clears the pending
    // flag so the wrap never produces an extra read.
    if (grant_i) begin
      if (idx_q == FLOW_LAST) pend_d = 1'b0;
      idx_d = idx_q + A_WIDTH'(1);
    end

    // An active sweep finishes on its own, independent of sweep_en_i.
    if (done_i) active_d = 1'b0;

    if (terminal) begin
      if (active_q) begin
        overrun_d = 1'b1;
      end else begin
        active_d = 1'b1;
        pend_d   = 1'b1;
        idx_d    = '0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge value of the others, independent of block order.
  always_ff @(posedge clk_i) begin
    // NOTE: the reset here is synchronous; it is sampled only at the edge.
    if (rst_i) begin
      cnt_q     <= '0;
      active_q  <= 1'b0;
      pend_q    <= 1'b0;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      pend_q    <= pend_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

  assign req_o     = pend_q;
  assign flow_o    = idx_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/stat_rd_sched.sv
// Read scheduler in front of stat_pkt. Arbitrates host read-and-clear
// requests against periodic sweep reads, keeps at most one read
// outstanding, and aborts a read after RD_TIMEOUT cycles with data 0.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : host request/ack/data, sweep enable and results,
//                  stat_pkt read strobe/flow and read data/valid
module stat_rd_sched
  import stat_pkt_pkg::*;
#(
  parameter int A_WIDTH      = 3,
  parameter int D_WIDTH      = 32,
  parameter int SWEEP_PERIOD = 1024,
  parameter int RD_TIMEOUT   = 16
) (
  input logic            clk_i,
  input logic            rst_i,
  stat_rd_sched_if.slave bus
);

  localparam int                 TW        = $clog2(RD_TIMEOUT + 1);
  localparam logic [TW-1:0]      WAIT_LAST = TW'(RD_TIMEOUT - 1);
  localparam logic [A_WIDTH-1:0] FLOW_LAST = '1;

  state_e             state_q, state_d;
  logic [TW-1:0]      wait_cnt_q, wait_cnt_d;
  req_id_e            owner_q, owner_d;
  req_id_e            last_q, last_d;
  logic [A_WIDTH-1:0] cur_flow_q, cur_flow_d;
  logic               rd_stb_q, rd_stb_d;
  logic               host_ack_q, host_ack_d;
  logic [D_WIDTH-1:0] host_data_q, host_data_d;
  logic               host_val_q, host_val_d;
  logic [D_WIDTH-1:0] sweep_data_q, sweep_data_d;
  logic               sweep_val_q, sweep_val_d;
  logic [A_WIDTH-1:0] sweep_flow_q, sweep_flow_d;
  logic               sweep_done_q, sweep_done_d;
  logic               timeout_q, timeout_d;

  logic               sweep_req;
  logic [A_WIDTH-1:0] sweep_flow;
  logic               sweep_overrun;
  logic               grant_host, grant_sweep;
  logic               deliver;
  logic [D_WIDTH-1:0] deliver_data;

  stat_sweep_timer #(
    .A_WIDTH      (A_WIDTH),
    .SWEEP_PERIOD (SWEEP_PERIOD)
  ) u_sweep_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .sweep_en_i (bus.sweep_en_i),
    .grant_i    (grant_sweep),
    .done_i     (sweep_done_d),
    .req_o      (sweep_req),
    .flow_o     (sweep_flow),
    .overrun_o  (sweep_overrun)
  );

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    owner_d      = owner_q;
    last_d       = last_q;
    cur_flow_d   = cur_flow_q;
    rd_stb_d     = 1'b0;
    host_ack_d   = 1'b0;
    host_data_d  = host_data_q;
    host_val_d   = 1'b0;
    sweep_data_d = sweep_data_q;
    sweep_val_d  = 1'b0;
    sweep_flow_d = sweep_flow_q;
    sweep_done_d = 1'b0;
    timeout_d    = 1'b0;
    grant_host   = 1'b0;
    grant_sweep  = 1'b0;
    deliver      = 1'b0;
    deliver_data = '0;

    case (state_q)
      ST_IDLE: begin
        // On a tie the requester that did not win last time is served.
        if (bus.host_req_i && sweep_req) begin
          if (last_q == REQ_SWEEP) grant_host  = 1'b1;
          else                     grant_sweep = 1'b1;
        end else begin
          grant_host  = bus.host_req_i;
          grant_sweep = sweep_req;
        end
        if (grant_host || grant_sweep) begin
          state_d    = ST_WAIT;
          wait_cnt_d = '0;
          rd_stb_d   = 1'b1;
          host_ack_d = grant_host;
          owner_d    = grant_host ? REQ_HOST : REQ_SWEEP;
          last_d     = grant_host ? REQ_HOST : REQ_SWEEP;
          cur_flow_d = grant_host ? bus.host_flow_num_i : sweep_flow;
        end
      end
      ST_WAIT: begin
        if (bus.rd_data_val_i) begin
          deliver      = 1'b1;
          deliver_data = bus.rd_data_i;
        end else if (wait_cnt_q == WAIT_LAST) begin
          deliver   = 1'b1;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Completion (real data or timeout) goes to whoever owns the read.
    if (deliver) begin
      state_d = ST_IDLE;
      if (owner_q == REQ_HOST) begin
        host_data_d = deliver_data;
        host_val_d  = 1'b1;
      end else begin
        sweep_data_d = deliver_data;
        sweep_flow_d = cur_flow_q;
        sweep_val_d  = 1'b1;
        sweep_done_d = (cur_flow_q == FLOW_LAST);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= '0;
      owner_q      <= REQ_HOST;
      last_q       <= REQ_SWEEP;  // host wins the first tie
      cur_flow_q   <= '0;
      rd_stb_q     <= 1'b0;
      host_ack_q   <= 1'b0;
      host_data_q  <= '0;
      host_val_q   <= 1'b0;
      sweep_data_q <= '0;
      sweep_val_q  <= 1'b0;
      sweep_flow_q <= '0;
      sweep_done_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      cur_flow_q   <= cur_flow_d;
      rd_stb_q     <= rd_stb_d;
      host_ack_q   <= host_ack_d;
      host_data_q  <= host_data_d;
      host_val_q   <= host_val_d;
      sweep_data_q <= sweep_data_d;
      sweep_val_q  <= sweep_val_d;
      sweep_flow_q <= sweep_flow_d;
      sweep_done_q <= sweep_done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.host_ack_o       = host_ack_q;
  assign bus.host_data_o      = host_data_q;
  assign bus.host_data_val_o  = host_val_q;
  assign bus.sweep_flow_num_o = sweep_flow_q;
  assign bus.sweep_data_o     = sweep_data_q;
  assign bus.sweep_data_val_o = sweep_val_q;
  assign bus.sweep_done_o     = sweep_done_q;
  assign bus.sweep_overrun_o  = sweep_overrun;
  assign bus.timeout_err_o    = timeout_q;
  assign bus.rd_stb_o         = rd_stb_q;
  assign bus.rd_flow_num_o    = cur_flow_q;

endmodule
